// File: rtl/cpu16_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu16_pipe_pkg
// Description : Shared opcodes, state encoding, flag indices and decode
//               helpers for the cpu16_pipe 5-stage pipelined CPU.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu16_pipe_pkg;

    // 5-bit opcodes (instruction bits [15:11])
    localparam logic [4:0] c_OP_NOP   = 5'b00000;
    localparam logic [4:0] c_OP_HALT  = 5'b00001;
    localparam logic [4:0] c_OP_LOAD  = 5'b00010;
    localparam logic [4:0] c_OP_STORE = 5'b00011;
    localparam logic [4:0] c_OP_SLL   = 5'b00100;
    localparam logic [4:0] c_OP_SLA   = 5'b00101;
    localparam logic [4:0] c_OP_SRL   = 5'b00110;
    localparam logic [4:0] c_OP_SRA   = 5'b00111;
    localparam logic [4:0] c_OP_ADD   = 5'b01000;
    localparam logic [4:0] c_OP_ADDI  = 5'b01001;
    localparam logic [4:0] c_OP_SUB   = 5'b01010;
    localparam logic [4:0] c_OP_SUBI  = 5'b01011;
    localparam logic [4:0] c_OP_CMP   = 5'b01100;
    localparam logic [4:0] c_OP_AND   = 5'b01101;
    localparam logic [4:0] c_OP_OR    = 5'b01110;
    localparam logic [4:0] c_OP_XOR   = 5'b01111;
    localparam logic [4:0] c_OP_LDIH  = 5'b10000;
    localparam logic [4:0] c_OP_ADDC  = 5'b10001;
    localparam logic [4:0] c_OP_SUBC  = 5'b10010;
    localparam logic [4:0] c_OP_SRR   = 5'b10011;
    localparam logic [4:0] c_OP_JUMP  = 5'b11000;
    localparam logic [4:0] c_OP_JMPR  = 5'b11001;
    localparam logic [4:0] c_OP_BZ    = 5'b11010;
    localparam logic [4:0] c_OP_BNZ   = 5'b11011;
    localparam logic [4:0] c_OP_BN    = 5'b11100;
    localparam logic [4:0] c_OP_BNN   = 5'b11101;
    localparam logic [4:0] c_OP_BC    = 5'b11110;
    localparam logic [4:0] c_OP_BNC   = 5'b11111;

    localparam logic [15:0] c_INSTR_NOP = 16'h0000;

    // Flag register bit positions
    localparam int c_FLAG_CF = 0;
    localparam int c_FLAG_ZF = 1;
    localparam int c_FLAG_NF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // True for opcodes whose result is written back to gr[r1]
    function automatic logic writes_reg(input logic [4:0] op);
        case (op)
            c_OP_LOAD, c_OP_SLL, c_OP_SLA, c_OP_SRL, c_OP_SRA,
            c_OP_ADD, c_OP_ADDI, c_OP_SUB, c_OP_SUBI,
            c_OP_AND, c_OP_OR, c_OP_XOR,
            c_OP_LDIH, c_OP_ADDC, c_OP_SUBC, c_OP_SRR: writes_reg = 1'b1;
            default:                                   writes_reg = 1'b0;
        endcase
    endfunction

    // True when a control-transfer opcode redirects the pc
    function automatic logic branch_taken(input logic [4:0] op, input logic [2:0] flags);
        case (op)
            c_OP_JUMP, c_OP_JMPR: branch_taken = 1'b1;
            c_OP_BZ:              branch_taken = flags[c_FLAG_ZF];
            c_OP_BNZ:             branch_taken = ~flags[c_FLAG_ZF];
            c_OP_BN:              branch_taken = flags[c_FLAG_NF];
            c_OP_BNN:             branch_taken = ~flags[c_FLAG_NF];
            c_OP_BC:              branch_taken = flags[c_FLAG_CF];
            c_OP_BNC:             branch_taken = ~flags[c_FLAG_CF];
            default:              branch_taken = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu16_pipe_alu.sv
`default_nettype none
// ============================================================================
// Module      : cpu16_alu
// Description : Combinational ALU for cpu16_pipe: add/sub with carry,
//               logic, shifts, rotate, and address/target generation.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu16_alu
    import cpu16_pipe_pkg::*;
(
    input  logic [4:0]  i_op,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cf,
    output logic [15:0] o_result,
    output logic        o_cf,
    output logic        o_zf,
    output logic        o_nf,
    output logic        o_flag_we
);

    logic        w_cin;
    logic        w_bin;
    logic [3:0]  w_sh;
    logic        w_sh_zero;
    logic [16:0] w_add;
    logic [16:0] w_sub;
    logic [16:0] w_shl;
    logic [16:0] w_shr_l;
    logic [16:0] w_shr_a;
    logic [31:0] w_rot;
    logic [15:0] w_res;
    logic        w_cf;
    logic        w_we;

    assign w_cin     = (i_op == c_OP_ADDC) ? i_cf : 1'b0;
    assign w_bin     = (i_op == c_OP_SUBC) ? i_cf : 1'b0;
    assign w_sh      = i_b[3:0];
    assign w_sh_zero = (w_sh == 4'd0);

    // Bit 16 of the adder is carry out; of the subtractor it is borrow out
    assign w_add   = {1'b0, i_a} + {1'b0, i_b} + {16'h0000, w_cin};
    assign w_sub   = {1'b0, i_a} - {1'b0, i_b} - {16'h0000, w_bin};
    // Extra guard bit catches the last bit shifted out on either side
    assign w_shl   = {1'b0, i_a} << w_sh;
    assign w_shr_l = {i_a, 1'b0} >> w_sh;
    assign w_shr_a = $signed({i_a, 1'b0}) >>> w_sh;
    assign w_rot   = {i_a, i_a} >> w_sh;

    // Result, carry and flag-update strobe selection by opcode
    always_comb begin
        w_res = 16'h0000;
        w_cf  = i_cf;
        w_we  = 1'b0;
        case (i_op)
            c_OP_ADD, c_OP_ADDI, c_OP_LDIH, c_OP_ADDC: begin
                w_res = w_add[15:0];
                w_cf  = w_add[16];
                w_we  = 1'b1;
            end
            c_OP_SUB, c_OP_SUBI, c_OP_CMP, c_OP_SUBC: begin
                w_res = w_sub[15:0];
                w_cf  = w_sub[16];
                w_we  = 1'b1;
            end
            c_OP_AND: begin w_res = i_a & i_b; w_cf = 1'b0; w_we = 1'b1; end
            c_OP_OR:  begin w_res = i_a | i_b; w_cf = 1'b0; w_we = 1'b1; end
            c_OP_XOR: begin w_res = i_a ^ i_b; w_cf = 1'b0; w_we = 1'b1; end
            c_OP_SLL, c_OP_SLA: begin
                w_res = w_shl[15:0];
                w_cf  = w_sh_zero ? i_cf : w_shl[16];
                w_we  = 1'b1;
            end
            c_OP_SRL: begin
                w_res = w_shr_l[16:1];
                w_cf  = w_sh_zero ? i_cf : w_shr_l[0];
                w_we  = 1'b1;
            end
            c_OP_SRA: begin
                w_res = w_shr_a[16:1];
                w_cf  = w_sh_zero ? i_cf : w_shr_a[0];
                w_we  = 1'b1;
            end
            c_OP_SRR: begin
                w_res = w_rot[15:0];
                w_cf  = w_sh_zero ? i_cf : w_rot[15];
                w_we  = 1'b1;
            end
            // Memory addresses and jump targets use the adder, flags untouched
            c_OP_LOAD, c_OP_STORE, c_OP_JUMP, c_OP_JMPR,
            c_OP_BZ, c_OP_BNZ, c_OP_BN, c_OP_BNN, c_OP_BC, c_OP_BNC: begin
                w_res = w_add[15:0];
            end
            default: ;
        endcase
    end

    assign o_result  = w_res;
    assign o_cf      = w_cf;
    assign o_zf      = (w_res == 16'h0000);
    assign o_nf      = w_res[15];
    assign o_flag_we = w_we;

endmodule
`default_nettype wire

// File: rtl/cpu16_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cpu16_pipe
// Description : 16-bit 5-stage (IF/ID/EX/MEM/WB) in-order pipelined CPU with
//               Harvard memory ports, no hazard detection or forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu16_pipe
    import cpu16_pipe_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] i_datain,
    output logic [7:0]  i_addr,
    input  logic [15:0] d_datain,
    output logic [7:0]  d_addr,
    output logic [15:0] d_dataout,
    output logic        d_we
);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_pc;
    logic [15:0] r_id_ir;
    logic [15:0] r_ex_ir;
    logic [15:0] r_mem_ir;
    logic [15:0] r_wb_ir;
    logic [15:0] r_reg_a;
    logic [15:0] r_reg_b;
    logic [15:0] r_reg_c;
    logic [15:0] r_reg_c1;
    logic [15:0] r_smdr;
    logic [2:0]  r_flag;
    logic [15:0] r_gr [8];

    // Instruction field decode per stage
    logic [4:0]  w_id_op;
    logic [2:0]  w_id_r1;
    logic [2:0]  w_id_r2;
    logic [2:0]  w_id_r3;
    logic [3:0]  w_id_f3;
    logic [7:0]  w_id_imm8;
    logic [4:0]  w_ex_op;
    logic [2:0]  w_ex_r1;
    logic [4:0]  w_mem_op;
    logic [4:0]  w_wb_op;
    logic [2:0]  w_wb_r1;

    assign w_id_op   = r_id_ir[15:11];
    assign w_id_r1   = r_id_ir[10:8];
    assign w_id_r2   = r_id_ir[6:4];
    assign w_id_r3   = r_id_ir[2:0];
    assign w_id_f3   = r_id_ir[3:0];
    assign w_id_imm8 = r_id_ir[7:0];
    assign w_ex_op   = r_ex_ir[15:11];
    assign w_ex_r1   = r_ex_ir[10:8];
    assign w_mem_op  = r_mem_ir[15:11];
    assign w_wb_op   = r_wb_ir[15:11];
    assign w_wb_r1   = r_wb_ir[10:8];

    // Later stages only need opcode/r1; the remaining IR bits travel along
    logic w_unused_bits;
    assign w_unused_bits = ^{r_ex_ir[7:0], r_mem_ir[10:0], r_wb_ir[7:0]};

    logic [15:0] w_opa;
    logic [15:0] w_opb;
    logic [15:0] w_alu_res;
    logic        w_alu_cf;
    logic        w_alu_zf;
    logic        w_alu_nf;
    logic        w_alu_flag_we;
    logic        w_branch;

    assign w_branch = branch_taken(w_mem_op, r_flag);

    // Control FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else if (enable)
            r_state <= w_next_state;
    end

    // Control FSM: next state (start launches, HALT retiring in WB stops)
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (enable && start)                w_next_state = ST_EXEC;
            ST_EXEC: if (enable && (w_wb_op == c_OP_HALT)) w_next_state = ST_IDLE;
            default:                                     w_next_state = ST_IDLE;
        endcase
    end

    // ID operand selection; immediates are steered into operand B
    always_comb begin
        w_opa = 16'h0000;
        w_opb = 16'h0000;
        case (w_id_op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR,
            c_OP_ADDC, c_OP_SUBC, c_OP_CMP: begin
                w_opa = r_gr[w_id_r2];
                w_opb = r_gr[w_id_r3];
            end
            c_OP_ADDI, c_OP_SUBI: begin
                w_opa = r_gr[w_id_r1];
                w_opb = {8'h00, w_id_imm8};
            end
            c_OP_LDIH: begin
                w_opa = r_gr[w_id_r1];
                w_opb = {w_id_imm8, 8'h00};
            end
            c_OP_SLL, c_OP_SLA, c_OP_SRL, c_OP_SRA, c_OP_SRR,
            c_OP_LOAD, c_OP_STORE: begin
                w_opa = r_gr[w_id_r2];
                w_opb = {12'h000, w_id_f3};
            end
            c_OP_JUMP: begin
                w_opb = {8'h00, w_id_imm8};
            end
            c_OP_JMPR, c_OP_BZ, c_OP_BNZ, c_OP_BN, c_OP_BNN, c_OP_BC, c_OP_BNC: begin
                w_opa = r_gr[w_id_r1];
                w_opb = {8'h00, w_id_imm8};
            end
            default: ;
        endcase
    end

    cpu16_alu u_alu (
        .i_op      (w_ex_op),
        .i_a       (r_reg_a),
        .i_b       (r_reg_b),
        .i_cf      (r_flag[c_FLAG_CF]),
        .o_result  (w_alu_res),
        .o_cf      (w_alu_cf),
        .o_zf      (w_alu_zf),
        .o_nf      (w_alu_nf),
        .o_flag_we (w_alu_flag_we)
    );

    // IF stage: fetch while executing, redirect pc when a taken branch is in MEM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc    <= 8'h00;
            r_id_ir <= c_INSTR_NOP;
        end else if (enable) begin
            if (r_state == ST_EXEC) begin
                r_id_ir <= i_datain;
                r_pc    <= w_branch ? r_reg_c[7:0] : r_pc + 8'd1;
            end else begin
                r_id_ir <= c_INSTR_NOP;
            end
        end
    end

    // ID/EX/MEM pipeline registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ex_ir  <= c_INSTR_NOP;
            r_mem_ir <= c_INSTR_NOP;
            r_wb_ir  <= c_INSTR_NOP;
            r_reg_a  <= 16'h0000;
            r_reg_b  <= 16'h0000;
            r_reg_c  <= 16'h0000;
            r_reg_c1 <= 16'h0000;
            r_smdr   <= 16'h0000;
        end else if (enable) begin
            r_ex_ir  <= r_id_ir;
            r_reg_a  <= w_opa;
            r_reg_b  <= w_opb;
            r_mem_ir <= r_ex_ir;
            r_reg_c  <= w_alu_res;
            r_smdr   <= r_gr[w_ex_r1];
            r_wb_ir  <= r_mem_ir;
            r_reg_c1 <= (w_mem_op == c_OP_LOAD) ? d_datain : r_reg_c;
        end
    end

    // Flags follow the EX-stage ALU when it reports a flag-affecting op
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_flag <= 3'b000;
        end else if (enable && w_alu_flag_we) begin
            r_flag[c_FLAG_CF] <= w_alu_cf;
            r_flag[c_FLAG_ZF] <= w_alu_zf;
            r_flag[c_FLAG_NF] <= w_alu_nf;
        end
    end

    // WB stage: register file write (gr[0] is an ordinary register)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++)
                r_gr[i] <= 16'h0000;
        end else if (enable && writes_reg(w_wb_op)) begin
            r_gr[w_wb_r1] <= r_reg_c1;
        end
    end

    assign i_addr    = r_pc;
    assign d_addr    = r_reg_c[7:0];
    assign d_dataout = r_smdr;
    assign d_we      = (w_mem_op == c_OP_STORE);

endmodule
`default_nettype wire

// File: tb/tb_cpu16_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu16_pipe
// Description : Directed self-checking bench for cpu16_pipe with a
//               combinational instruction ROM and fixed load data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu16_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        start;
    logic [15:0] i_datain;
    logic [7:0]  i_addr;
    logic [15:0] d_datain;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic        d_we;

    logic [15:0] rom [256];

    int n_checks = 0;
    int n_fail   = 0;

    cpu16_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .i_datain  (i_datain),
        .i_addr    (i_addr),
        .d_datain  (d_datain),
        .d_addr    (d_addr),
        .d_dataout (d_dataout),
        .d_we      (d_we)
    );

    always #5 clock = ~clock;

    assign i_datain = rom[i_addr];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for the pc to present address a; returns at a falling edge
    task automatic wait_pc(input logic [7:0] a);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clock);
            if (i_addr == a) found = 1'b1;
        end
        chk("wait_pc", 16'(found), 16'h0001);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h81AB; // LDIH r1,AB      -> gr1=AB00
        rom[8'h04] = 16'h49CD; // ADDI r1,CD      -> gr1=ABCD
        rom[8'h08] = 16'h9814; // SRR  r0,r1,4    -> gr0=DABC
        rom[8'h0C] = 16'h5111; // SUB  r1,r1,r1   -> gr1=0
        rom[8'h0D] = 16'h4A01; // ADDI r2,01      -> gr2=1
        rom[8'h10] = 16'h817F; // LDIH r1,7F      -> gr1=7F00
        rom[8'h14] = 16'h49FF; // ADDI r1,FF      -> gr1=7FFF
        rom[8'h18] = 16'h4312; // ADD  r3,r1,r2   -> gr3=8000
        rom[8'h1B] = 16'h4A0F; // ADDI r2,0F      -> gr2=0010
        rom[8'h1C] = 16'h5422; // SUB  r4,r2,r2   -> gr4=0, zf=1
        rom[8'h20] = 16'h1923; // STORE r1,(r2+3) -> mem[13]=7FFF
        rom[8'h24] = 16'h1520; // LOAD r5,(r2+0)  -> gr5=1234
        rom[8'h28] = 16'hD450; // BZ   r4,50      -> taken
        rom[8'h29] = 16'h4E01; // ADDI r6,01      delay slot, executes
        rom[8'h2C] = 16'h4E10; // ADDI r6,10      skipped by branch
        rom[8'h50] = 16'h4F05; // ADDI r7,05      -> gr7=5
        rom[8'h51] = 16'h6044; // CMP  r4,r4      -> zf=1, no write
        rom[8'h54] = 16'h0800; // HALT
        rom[8'h59] = 16'h4F01; // ADDI r7,01      in flight at reset

        reset    = 1'b0;
        enable   = 1'b0;
        start    = 1'b0;
        d_datain = 16'h1234;

        // Reset state
        #3;
        chk("rst_i_addr", 16'(i_addr), 16'h0000);
        chk("rst_d_we", 16'(d_we), 16'h0000);
        chk("rst_d_addr", 16'(d_addr), 16'h0000);
        chk("rst_d_dataout", d_dataout, 16'h0000);
        chk("rst_state", 16'(dut.r_state), 16'h0000);

        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_state", 16'(dut.r_state), 16'h0001);
        chk("start_pc0", 16'(i_addr), 16'h0000);
        @(negedge clock);
        chk("start_pc1", 16'(i_addr), 16'h0001);
        chk("start_d_we", 16'(d_we), 16'h0000);

        // SRR latency: result lands exactly five edges after pc presents it
        wait_pc(8'h08);
        step(4);
        chk("srr_gr0_early", dut.r_gr[0], 16'h0000);
        step(1);
        chk("srr_gr0", dut.r_gr[0], 16'hDABC);
        chk("srr_nf", 16'(dut.r_flag[2]), 16'h0001);
        chk("srr_zf", 16'(dut.r_flag[1]), 16'h0000);
        chk("srr_pc", 16'(i_addr), 16'h000D);
        chk("srr_id_ir", dut.r_id_ir, 16'h5111);

        // Global stall
        enable = 1'b0;
        step(4);
        chk("stall_pc", 16'(i_addr), 16'h000D);
        chk("stall_id_ir", dut.r_id_ir, 16'h5111);
        chk("stall_gr0", dut.r_gr[0], 16'hDABC);
        chk("stall_gr1", dut.r_gr[1], 16'hABCD);
        enable = 1'b1;

        // ADD overflow into sign bit
        wait_pc(8'h18);
        step(5);
        chk("add_gr3", dut.r_gr[3], 16'h8000);
        chk("add_nf", 16'(dut.r_flag[2]), 16'h0001);
        chk("add_cf", 16'(dut.r_flag[0]), 16'h0000);
        chk("add_zf", 16'(dut.r_flag[1]), 16'h0000);

        // SUB to zero
        step(4);
        chk("sub_gr4", dut.r_gr[4], 16'h0000);
        chk("sub_zf", 16'(dut.r_flag[1]), 16'h0001);
        chk("sub_nf", 16'(dut.r_flag[2]), 16'h0000);
        chk("sub_cf", 16'(dut.r_flag[0]), 16'h0000);

        // STORE: write strobe for exactly one cycle while in MEM
        step(1);
        chk("st_we_before", 16'(d_we), 16'h0000);
        step(1);
        chk("st_we", 16'(d_we), 16'h0001);
        chk("st_addr", 16'(d_addr), 16'h0013);
        chk("st_data", d_dataout, 16'h7FFF);
        step(1);
        chk("st_we_after", 16'(d_we), 16'h0000);
        chk("st_zf_kept", 16'(dut.r_flag[1]), 16'h0001);

        // LOAD
        step(5);
        chk("ld_gr5", dut.r_gr[5], 16'h1234);
        chk("ld_zf_kept", 16'(dut.r_flag[1]), 16'h0001);

        // BZ taken after three delay slots
        step(2);
        chk("bz_pc_slot", 16'(i_addr), 16'h002B);
        step(1);
        chk("bz_pc_target", 16'(i_addr), 16'h0050);

        // HALT retiring in WB -> idle, pc frozen
        step(9);
        chk("halt_state", 16'(dut.r_state), 16'h0000);
        chk("halt_pc", 16'(i_addr), 16'h0059);
        step(3);
        chk("halt_pc_frozen", 16'(i_addr), 16'h0059);
        chk("halt_state_kept", 16'(dut.r_state), 16'h0000);
        chk("fin_gr0", dut.r_gr[0], 16'hDABC);
        chk("fin_gr1", dut.r_gr[1], 16'h7FFF);
        chk("fin_gr2", dut.r_gr[2], 16'h0010);
        chk("fin_gr3", dut.r_gr[3], 16'h8000);
        chk("fin_gr4", dut.r_gr[4], 16'h0000);
        chk("fin_gr5", dut.r_gr[5], 16'h1234);
        chk("fin_gr6", dut.r_gr[6], 16'h0001);
        chk("fin_gr7", dut.r_gr[7], 16'h0005);
        chk("fin_zf", 16'(dut.r_flag[1]), 16'h0001);

        // start while stalled is ignored
        enable = 1'b0;
        start  = 1'b1;
        step(1);
        chk("stall_start_state", 16'(dut.r_state), 16'h0000);
        start  = 1'b0;
        enable = 1'b1;

        // Restart, then asynchronous reset mid-program
        start = 1'b1;
        step(1);
        chk("restart_state", 16'(dut.r_state), 16'h0001);
        start = 1'b0;
        step(2);
        chk("restart_ex_ir", dut.r_ex_ir, 16'h4F01);
        reset = 1'b0;
        #1;
        chk("arst_pc", 16'(i_addr), 16'h0000);
        chk("arst_state", 16'(dut.r_state), 16'h0000);
        chk("arst_d_we", 16'(d_we), 16'h0000);
        chk("arst_d_addr", 16'(d_addr), 16'h0000);
        chk("arst_d_dataout", d_dataout, 16'h0000);
        chk("arst_id_ir", dut.r_id_ir, 16'h0000);
        chk("arst_ex_ir", dut.r_ex_ir, 16'h0000);
        chk("arst_flags", 16'(dut.r_flag), 16'h0000);
        for (int i = 0; i < 8; i++)
            chk($sformatf("arst_gr%0d", i), dut.r_gr[i], 16'h0000);
        @(negedge clock);
        reset = 1'b1;
        step(6);
        chk("post_rst_gr7", dut.r_gr[7], 16'h0000);
        chk("post_rst_pc", 16'(i_addr), 16'h0000);
        chk("post_rst_state", 16'(dut.r_state), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
